// File: rtl/ss_pkt_sink.sv
// ss stream receive endpoint: DEPTH-beat buffer with a first-word-fall-through read port.
// Define SS_PKT_SINK_DROP_EN for store-and-forward operation with whole-packet drop on overflow.
module ss_pkt_sink #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 1,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  input  logic [USER_W-1:0] s_user,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [KEEP_W-1:0] rd_keep,
  output logic              rd_last,
  output logic [USER_W-1:0] rd_user,
  output logic [AW:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned EW      = DATA_W + KEEP_W + 1 + USER_W;
  localparam logic [AW:0] PtrOne  = (AW+1)'(1);
  localparam logic [AW:0] PtrFull = (AW+1)'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_pkt_cnt;
  logic          r_run;

  logic [AW:0]   w_commit_ptr;
  logic [AW:0]   w_fill;
  logic          w_full;
  logic          w_empty;
  logic          w_acc;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_pkt_inc;
  logic          w_pkt_dec;
  logic [EW-1:0] w_head;

  // Both flags come from registered pointers only, so s_ready never depends on s_valid or rd_en.
  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == PtrFull);
  assign w_empty = (w_commit_ptr == r_rd_ptr);

  assign w_acc  = s_valid && s_ready;
  assign w_pop  = rd_en && rd_valid;
  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  assign rd_valid = !w_empty;
  assign {rd_data, rd_keep, rd_last, rd_user} = w_head;
  assign pkt_cnt   = r_pkt_cnt;
  assign w_pkt_dec = w_pop && rd_last;

  // Holds s_ready low throughout reset and releases it on the first clock afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Storage is not reset; rd_* are don't-care while rd_valid is low.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {s_data, s_keep, s_last, s_user};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_cnt <= '0;
    end else begin
      unique case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PtrOne;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PtrOne;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

`ifdef SS_PKT_SINK_DROP_EN

  typedef enum logic {StPass, StDrop} state_e;

  state_e      r_state;
  logic [AW:0] r_commit_ptr;
  logic [15:0] r_drop_cnt;
  logic [15:0] w_drop_inc;

  // Overflow is handled by dropping, so the sink never backpressures outside reset.
  assign s_ready      = r_run;
  assign w_wr_en      = w_acc && (r_state == StPass) && !w_full;
  assign w_pkt_inc    = w_wr_en && s_last;
  assign w_commit_ptr = r_commit_ptr;
  assign drop_cnt     = r_drop_cnt;
  assign w_drop_inc   = (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : r_drop_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StPass;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_drop_cnt   <= '0;
    end else begin
      unique case (r_state)
        StPass: begin
          if (w_acc) begin
            if (!w_full) begin
              r_wr_ptr <= r_wr_ptr + PtrOne;
              if (s_last) begin
                r_commit_ptr <= r_wr_ptr + PtrOne;
              end
            end else begin
              // Rewind over the partial packet; the rest of it is swallowed in StDrop.
              r_wr_ptr <= r_commit_ptr;
              if (s_last) begin
                r_drop_cnt <= w_drop_inc;
              end else begin
                r_state <= StDrop;
              end
            end
          end
        end
        StDrop: begin
          if (w_acc && s_last) begin
            r_drop_cnt <= w_drop_inc;
            r_state    <= StPass;
          end
        end
      endcase
    end
  end

`else

  assign s_ready      = r_run && !w_full;
  assign w_wr_en      = w_acc;
  assign w_pkt_inc    = w_acc && s_last;
  assign w_commit_ptr = r_wr_ptr;
  assign drop_cnt     = 16'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + PtrOne;
    end
  end

`endif

endmodule

// File: tb/tb_ss_pkt_sink.sv
// Self-checking bench for ss_pkt_sink: constant vector table, hand-written corner sequences and
// randomized traffic against a queue-based packet model. Follows SS_PKT_SINK_DROP_EN like the DUT.
module tb_ss_pkt_sink;

`ifdef SS_PKT_SINK_DROP_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif
  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic [0:0]  s_user = '0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [7:0]  rd_keep;
  logic        rd_last;
  logic [0:0]  rd_user;
  logic [4:0]  pkt_cnt;
  logic [15:0] drop_cnt;

  ss_pkt_sink #(.DATA_W(64), .USER_W(1), .DEPTH(Depth)) dut (
    .clk(clk), .rst(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_user(s_user),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_keep(rd_keep),
    .rd_last(rd_last), .rd_user(rd_user),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  // Model: committed packets readable by local logic, plus the packet still arriving.
  beat_t cq[$];
  beat_t pq[$];
  beat_t got[$];
  int    m_drop = 0;
  bit    m_dropping = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_full();
    return (cq.size() + pq.size()) == Depth;
  endfunction

  function automatic int m_pkts();
    int n = 0;
    foreach (cq[i]) if (cq[i].l) n++;
    return n;
  endfunction

  function automatic void m_accept(input beat_t b, input bit full);
    if (!DropEn) begin
      if (!full) cq.push_back(b);
    end else if (m_dropping) begin
      if (b.l) begin
        if (m_drop < 65535) m_drop++;
        m_dropping = 1'b0;
      end
    end else if (full) begin
      pq.delete();
      if (b.l) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        m_dropping = 1'b1;
      end
    end else begin
      pq.push_back(b);
      if (b.l) begin
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
      end
    end
  endfunction

  // One clock: drive, compare every output with the model, clock, advance the model.
  task automatic cycle(input bit v, input logic [63:0] d, input logic [7:0] k, input bit l,
                       input bit u, input bit r);
    beat_t b;
    bit    full;
    bit    acc;
    bit    pop;
    s_valid = v; s_data = d; s_keep = k; s_last = l; s_user = u; rd_en = r;
    #1;
    full = m_full();
    chk("s_ready", 64'(s_ready), 64'(DropEn || !full));
    chk("rd_valid", 64'(rd_valid), 64'(cq.size() != 0));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts()));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (cq.size() != 0) begin
      chk("rd_data", rd_data, cq[0].d);
      chk("rd_keep", 64'(rd_keep), 64'(cq[0].k));
      chk("rd_last", 64'(rd_last), 64'(cq[0].l));
      chk("rd_user", 64'(rd_user), 64'(cq[0].u));
    end
    acc = v && (DropEn || !full);
    pop = r && (cq.size() != 0);
    @(posedge clk);
    #1;
    if (pop) got.push_back(cq.pop_front());
    if (acc) begin
      b.d = d; b.k = k; b.l = l; b.u = u;
      m_accept(b, full);
    end
  endtask

  task automatic idle(input bit r);
    cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, r);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; rd_en = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cq.delete(); pq.delete(); got.delete();
    m_drop = 0; m_dropping = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        l;
    logic        r;
    logic        e_ready;
    logic        e_rvalid;
    logic [4:0]  e_pkt;
    logic [63:0] e_data;
    logic        e_last;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic l, input logic r,
                              input logic er, input logic ev, input logic [4:0] ep,
                              input logic [63:0] ed, input logic el);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.e_ready = er; t.e_rvalid = ev; t.e_pkt = ep; t.e_data = ed; t.e_last = el;
    return t;
  endfunction

  initial begin
    vec_t        tbl[10];
    int          n_notready;
    int          run;
    int          rate;
    logic [63:0] sent[$];
    bit          lst;
    logic [63:0] rnd;

    // Expected state just before each edge for a 4-beat packet (data 1..4) read out afterwards.
    tbl[0] = mk(0, 0, 0, 0, 1, 0,       0, 0, 0);
    tbl[1] = mk(1, 1, 0, 0, 1, 0,       0, 0, 0);
    tbl[2] = mk(1, 2, 0, 0, 1, !DropEn, 0, 1, 0);
    tbl[3] = mk(1, 3, 0, 0, 1, !DropEn, 0, 1, 0);
    tbl[4] = mk(1, 4, 1, 0, 1, !DropEn, 0, 1, 0);
    tbl[5] = mk(0, 0, 0, 1, 1, 1,       1, 1, 0);
    tbl[6] = mk(0, 0, 0, 1, 1, 1,       1, 2, 0);
    tbl[7] = mk(0, 0, 0, 1, 1, 1,       1, 3, 0);
    tbl[8] = mk(0, 0, 0, 1, 1, 1,       1, 4, 1);
    tbl[9] = mk(0, 0, 0, 0, 1, 0,       0, 0, 0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l; rd_en = tbl[i].r;
      s_keep = 8'hFF; s_user = 1'b0;
      #1;
      chk($sformatf("tbl%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rvalid));
      chk($sformatf("tbl%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(tbl[i].e_pkt));
      if (tbl[i].e_rvalid) begin
        chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].e_data);
        chk($sformatf("tbl%0d_rd_last", i), 64'(rd_last), 64'(tbl[i].e_last));
      end
      @(posedge clk);
      #1;
    end

`ifdef SS_PKT_SINK_DROP_EN
    // 10-beat packet kept, second 10-beat packet overflows at its 7th beat.
    do_reset();
    for (int i = 1; i <= 10; i++) cycle(1'b1, 64'(i), 8'hFF, i == 10, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) cycle(1'b1, 64'(100 + i), 8'hFF, i == 10, 1'b1, 1'b0);
    idle(1'b0);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_pkt_cnt", 64'(pkt_cnt), 64'd1);
    for (int i = 0; i < 11; i++) idle(1'b1);
    chk("ovf_read_len", 64'(got.size()), 64'd10);
    foreach (got[i]) chk($sformatf("ovf_read%0d", i), got[i].d, 64'(i + 1));
    chk("ovf_empty", 64'(rd_valid), 64'd0);

    // Packet longer than the buffer, then a short packet must still get through.
    do_reset();
    for (int i = 1; i <= 20; i++) cycle(1'b1, 64'(i), 8'hFF, i == 20, 1'b0, 1'b0);
    idle(1'b0);
    chk("long_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("long_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("long_rd_valid", 64'(rd_valid), 64'd0);
    cycle(1'b1, 64'hA1, 8'h0F, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 64'hA2, 8'hF0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("long_next_len", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("long_next0", got[0].d, 64'hA1);
      chk("long_next1", got[1].d, 64'hA2);
      chk("long_next1_last", 64'(got[1].l), 64'd1);
    end
`else
    // Seventeen single-beat packets against a 16-entry buffer: backpressure, then one pop frees a slot.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 64'(i), 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("bp_s_ready_low", 64'(s_ready), 64'd0);
    chk("bp_pkt_cnt16", 64'(pkt_cnt), 64'd16);
    cycle(1'b1, 64'd16, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("bp_s_ready_back", 64'(s_ready), 64'd1);
    cycle(1'b1, 64'd16, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("bp_pkt_cnt_after", 64'(pkt_cnt), 64'd16);
    chk("bp_popped_first", 64'(got.size() == 1 ? got[0].d : 64'hDEAD), 64'd0);
`endif

    // Reset in the middle of a packet, then a clean packet.
    do_reset();
    cycle(1'b1, 64'h11, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h12, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("mid_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("mid_drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 64'(32 + i), 8'hFF, i == 4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("mid_next_len", 64'(got.size()), 64'd4);
    foreach (got[i]) chk($sformatf("mid_next%0d", i), got[i].d, 64'(33 + i));

    // 100 back-to-back random beats with the reader always enabled.
    do_reset();
    n_notready = 0;
    run = 0;
    sent.delete();
    for (int i = 0; i < 100; i++) begin
      run++;
      lst = ($urandom_range(0, 3) == 0) || (run == 8) || (i == 99);
      if (lst) run = 0;
      rnd = {$urandom(), $urandom()};
      sent.push_back(rnd);
      #1;
      if (!s_ready) n_notready++;
      cycle(1'b1, rnd, 8'($urandom()), lst, 1'($urandom()), 1'b1);
    end
    for (int i = 0; i < 12; i++) idle(1'b1);
    chk("stream_ready_held", 64'(n_notready), 64'd0);
    chk("stream_len", 64'(got.size()), 64'd100);
    if (got.size() == 100) begin
      foreach (sent[i]) chk($sformatf("stream%0d", i), got[i].d, sent[i]);
    end

    // Random traffic with varying reader duty cycle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rate = (i / 500) % 3 == 0 ? 15 : ((i / 500) % 3 == 1 ? 55 : 90);
      cycle($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, 8'($urandom()),
            $urandom_range(0, 5) == 0, 1'($urandom()), $urandom_range(0, 99) < rate);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
